// File: rtl/load_store_aligner.sv
// Load/store aligner: turns byte/half/word requests into word-aligned, byte-enabled storage beats.
// Define MISALIGNED_SPLIT_EN to split word-crossing accesses into two beats; otherwise they are rejected.
module load_store_aligner #(
  parameter int ADRESS_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic                   ReqWrite,
  input  logic [1:0]             ReqSize,
  input  logic                   ReqUnsigned,
  input  logic [ADRESS_SIZE-1:0] ReqAdress,
  input  logic [31:0]            ReqData,
  output logic                   MemEn,
  output logic                   WriteEnable,
  output logic [3:0]             ByteEn,
  output logic [ADRESS_SIZE-1:0] MemoryAdress,
  output logic [31:0]            InputData,
  input  logic [31:0]            MemData,
  output logic                   RespValid,
  output logic [31:0]            RespData,
  output logic                   RespError
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] r, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'b00:   return uns ? {24'h0, r[7:0]} : {{24{r[7]}}, r[7:0]};
      2'b01:   return uns ? {16'h0, r[15:0]} : {{16{r[15]}}, r[15:0]};
      default: return r;
    endcase
  endfunction

  state_t                   state_q, state_d;
  logic                     write_q, write_d, uns_q, uns_d;
  logic [1:0]               size_q, size_d;
  logic [ADRESS_SIZE-1:0]   addr_q, addr_d;
  logic [31:0]              data_q, data_d, lo_q, lo_d;
  logic                     mem_en_q, mem_en_d, we_q, we_d;
  logic [3:0]               be_q, be_d;
  logic [ADRESS_SIZE-1:0]   maddr_q, maddr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0]              resp_data_q, resp_data_d;

  // Lane math runs on the incoming request in IDLE and on the latched request afterwards.
  logic                     idle;
  logic [1:0]               src_size, src_off;
  logic [ADRESS_SIZE-1:0]   src_addr, src_base;
  logic [31:0]              src_data;
  logic [7:0]               src_mask;
  logic [63:0]              src_shift;
  logic                     crosses;
  logic [63:0]              ld_word;
  logic [31:0]              ld_shift, ld_result;

  assign idle      = (state_q == IDLE);
  assign src_addr  = idle ? ReqAdress : addr_q;
  assign src_size  = idle ? ReqSize : size_q;
  assign src_data  = idle ? ReqData : data_q;
  assign src_off   = src_addr[1:0];
  assign src_base  = {src_addr[ADRESS_SIZE-1:2], 2'b00};
  assign src_mask  = lane_mask(src_size, src_off);
  assign src_shift = {32'h0, src_data} << {src_off, 3'b000};
  assign crosses   = |src_mask[7:4];

  assign ld_word   = (state_q == BEAT1) ? {MemData, lo_q} : {32'h0, MemData};
  assign ld_shift  = 32'(ld_word >> {addr_q[1:0], 3'b000});
  assign ld_result = write_q ? 32'h0 : extend(ld_shift, size_q, uns_q);

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    uns_d        = uns_q;
    size_d       = size_q;
    addr_d       = addr_q;
    data_d       = data_q;
    lo_d         = lo_q;
    mem_en_d     = 1'b0;
    we_d         = 1'b0;
    be_d         = 4'h0;
    maddr_d      = '0;
    wdata_d      = 32'h0;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (ReqValid && ReqReady) begin
          state_d = BEAT0;
          write_d = ReqWrite;
          uns_d   = ReqUnsigned;
          size_d  = ReqSize;
          addr_d  = ReqAdress;
          data_d  = ReqData;
`ifdef MISALIGNED_SPLIT_EN
          mem_en_d = 1'b1;
`else
          mem_en_d = !crosses;
`endif
          if (mem_en_d) begin
            we_d    = ReqWrite;
            be_d    = src_mask[3:0];
            maddr_d = src_base;
            wdata_d = src_shift[31:0] & lane_bits(src_mask[3:0]);
          end
        end
      end
      BEAT0: begin
        lo_d = MemData;
`ifdef MISALIGNED_SPLIT_EN
        if (crosses) begin
          state_d  = BEAT1;
          mem_en_d = 1'b1;
          we_d     = write_q;
          be_d     = src_mask[7:4];
          maddr_d  = src_base + ADRESS_SIZE'(4);
          wdata_d  = src_shift[63:32] & lane_bits(src_mask[7:4]);
        end else begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = ld_result;
        end
`else
        state_d      = DONE;
        resp_valid_d = 1'b1;
        resp_err_d   = crosses;
        resp_data_d  = crosses ? 32'h0 : ld_result;
`endif
      end
      BEAT1: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = ld_result;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_en_q     <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= 4'h0;
      maddr_q      <= '0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_en_q     <= mem_en_d;
      we_q         <= we_d;
      be_q         <= be_d;
      maddr_q      <= maddr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Request latch and first load word; only meaningful once the FSM has left IDLE.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    uns_q   <= uns_d;
    size_q  <= size_d;
    addr_q  <= addr_d;
    data_q  <= data_d;
    lo_q    <= lo_d;
  end

  assign ReqReady     = reset && idle;
  assign MemEn        = mem_en_q;
  assign WriteEnable  = we_q;
  assign ByteEn       = be_q;
  assign MemoryAdress = maddr_q;
  assign InputData    = wdata_q;
  assign RespValid    = resp_valid_q;
  assign RespData     = resp_data_q;
  assign RespError    = resp_err_q;

endmodule

// File: tb/tb_load_store_aligner.sv
// Directed bench for load_store_aligner with a byte-lane storage model and beat/response scoreboards.
module tb_load_store_aligner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWrite = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqUnsigned = 1'b0;
  logic [31:0] ReqAdress = 32'h0;
  logic [31:0] ReqData = 32'h0;
  logic        MemEn, WriteEnable;
  logic [3:0]  ByteEn;
  logic [31:0] MemoryAdress, InputData, MemData;
  logic        RespValid, RespError;
  logic [31:0] RespData;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        we;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  beat_t bq[$];
  resp_t rq[$];

  int checks = 0;
  int passes = 0;

  logic [31:0] mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_data = 32'h0;

  load_store_aligner #(.ADRESS_SIZE(32)) dut (
    .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned),
    .ReqAdress(ReqAdress), .ReqData(ReqData), .MemEn(MemEn), .WriteEnable(WriteEnable),
    .ByteEn(ByteEn), .MemoryAdress(MemoryAdress), .InputData(InputData), .MemData(MemData),
    .RespValid(RespValid), .RespData(RespData), .RespError(RespError)
  );

  always #5 clk = ~clk;

  assign MemData = mem[MemoryAdress[9:2]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (MemEn && WriteEnable)
      for (int i = 0; i < 4; i++)
        if (ByteEn[i]) mem[MemoryAdress[9:2]][8*i +: 8] <= InputData[8*i +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = a[9:2]; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                           input logic we);
    bq.push_back('{a, be, d, we});
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    resp_t r;
    beat_t b;
    bit    got;
    int    w;
    rq.push_back('{exp_data, exp_err});
    @(negedge clk);
    w = 0;
    while (!ReqReady && w < 10) begin @(negedge clk); w++; end
    chk({tag, " ReqReady before accept"}, 32'(ReqReady), 32'h1);
    ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqUnsigned = uns; ReqAdress = a; ReqData = d;
    @(posedge clk); #1;
    ReqValid = 1'b0; ReqData = 32'h0;
    got = 1'b0;
    for (int cyc = 1; cyc <= 6 && !got; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk({tag, " ReqReady busy"}, 32'(ReqReady), 32'h0);
      if (MemEn) begin
        if (bq.size() == 0) chk({tag, " unexpected beat MemEn"}, 32'(MemEn), 32'h0);
        else begin
          b = bq.pop_front();
          chk({tag, " beat addr"}, MemoryAdress, b.addr);
          chk({tag, " beat ByteEn"}, 32'(ByteEn), 32'(b.be));
          chk({tag, " beat data"}, InputData, b.data);
          chk({tag, " beat we"}, 32'(WriteEnable), 32'(b.we));
        end
      end
      if (RespValid) begin
        got = 1'b1;
        chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        r = rq.pop_front();
        chk({tag, " RespData"}, RespData, r.data);
        chk({tag, " RespError"}, 32'(RespError), 32'(r.err));
        chk({tag, " bus idle in DONE"},
            {27'h0, MemEn, ByteEn} | MemoryAdress | InputData | 32'(WriteEnable), 32'h0);
      end
    end
    if (!got) begin
      chk({tag, " RespValid timeout"}, 32'(RespValid), 32'h1);
      void'(rq.pop_front());
    end
    chk({tag, " beats outstanding"}, 32'(bq.size()), 32'h0);
    bq.delete();
    @(negedge clk);
    chk({tag, " RespData hold"}, RespData, exp_data);
    chk({tag, " RespValid single pulse"}, 32'(RespValid), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Reset state
    @(negedge clk);
    chk("reset ReqReady", 32'(ReqReady), 32'h0);
    chk("reset RespValid", 32'(RespValid), 32'h0);
    chk("reset bus", {27'h0, MemEn, ByteEn} | MemoryAdress | InputData | 32'(WriteEnable), 32'h0);
    chk("reset resp", RespData | 32'(RespError), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("release ReqReady", 32'(ReqReady), 32'h1);

    // Aligned word store
    push_beat(32'h100, 4'b1111, 32'hDEADBEEF, 1'b1);
    do_req("st_w_100", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("mem 0x100 after word store", mem[8'h40], 32'hDEADBEEF);

    // Byte / half loads from 0x80FF1234
    preload(32'h100, 32'h80FF1234);
    push_beat(32'h100, 4'b1000, 32'h0, 1'b0);
    do_req("ld_b_103_s", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    push_beat(32'h100, 4'b1000, 32'h0, 1'b0);
    do_req("ld_b_103_u", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h00000080, 1'b0, 2);
    push_beat(32'h100, 4'b1100, 32'h0, 1'b0);
    do_req("ld_h_102_u", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h000080FF, 1'b0, 2);
    push_beat(32'h100, 4'b1100, 32'h0, 1'b0);
    do_req("ld_h_102_s", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF80FF, 1'b0, 2);

    // Byte store with junk in the upper data bits
    push_beat(32'h100, 4'b0010, 32'h00005A00, 1'b1);
    do_req("st_b_101", 1'b1, 2'b00, 1'b0, 32'h101, 32'hAABBCC5A, 32'h0, 1'b0, 2);
    chk("mem 0x100 after byte store", mem[8'h40], 32'h80FF5A34);

    // Misaligned word store
    preload(32'h104, 32'h0);
`ifdef MISALIGNED_SPLIT_EN
    push_beat(32'h100, 4'b1100, 32'h33440000, 1'b1);
    push_beat(32'h104, 4'b0011, 32'h00001122, 1'b1);
    do_req("st_w_102", 1'b1, 2'b10, 1'b0, 32'h102, 32'h11223344, 32'h0, 1'b0, 3);
    chk("mem 0x100 after split store", mem[8'h40], 32'h33445A34);
    chk("mem 0x104 after split store", mem[8'h41], 32'h00001122);
`else
    do_req("st_w_102", 1'b1, 2'b10, 1'b0, 32'h102, 32'h11223344, 32'h0, 1'b1, 2);
    chk("mem 0x100 after rejected store", mem[8'h40], 32'h80FF5A34);
    chk("mem 0x104 after rejected store", mem[8'h41], 32'h0);
`endif

    // Misaligned half load and the address-wrap case
    preload(32'hFC, 32'hAB000000);
    preload(32'h100, 32'h000000CD);
    preload(32'hFFFFFFFC, 32'h56780000);
    preload(32'h0, 32'h00001234);
`ifdef MISALIGNED_SPLIT_EN
    push_beat(32'hFC, 4'b1000, 32'h0, 1'b0);
    push_beat(32'h100, 4'b0001, 32'h0, 1'b0);
    do_req("ld_h_0ff_s", 1'b0, 2'b01, 1'b0, 32'hFF, 32'h0, 32'hFFFFCDAB, 1'b0, 3);
    push_beat(32'hFFFFFFFC, 4'b1100, 32'h0, 1'b0);
    push_beat(32'h0, 4'b0011, 32'h0, 1'b0);
    do_req("ld_w_wrap", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h12345678, 1'b0, 3);
`else
    do_req("ld_h_0ff_s", 1'b0, 2'b01, 1'b0, 32'hFF, 32'h0, 32'h0, 1'b1, 2);
    do_req("ld_w_wrap", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b1, 2);
`endif

    // Misaligned word load, then aligned loads (size 11 acts as word)
    preload(32'h100, 32'h44332211);
    preload(32'h104, 32'h88776655);
`ifdef MISALIGNED_SPLIT_EN
    push_beat(32'h100, 4'b1110, 32'h0, 1'b0);
    push_beat(32'h104, 4'b0001, 32'h0, 1'b0);
    do_req("ld_w_101", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h55443322, 1'b0, 3);
`else
    do_req("ld_w_101", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 2);
`endif
    push_beat(32'h104, 4'b1111, 32'h0, 1'b0);
    do_req("ld_w_104", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h88776655, 1'b0, 2);
    push_beat(32'h100, 4'b1111, 32'h0, 1'b0);
    do_req("ld_sz3_100", 1'b0, 2'b11, 1'b1, 32'h100, 32'h0, 32'h44332211, 1'b0, 2);

    // Reset in the middle of an access
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b01; ReqUnsigned = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
    ReqAdress = 32'hFF;
`else
    ReqAdress = 32'h100;
`endif
    @(posedge clk); #1;
    ReqValid = 1'b0;
    @(negedge clk);
`ifdef MISALIGNED_SPLIT_EN
    @(negedge clk);
`endif
    chk("midrst MemEn before reset", 32'(MemEn), 32'h1);
    reset = 1'b0;
    #1;
    chk("midrst bus cleared", {27'h0, MemEn, ByteEn} | MemoryAdress | InputData, 32'h0);
    chk("midrst ReqReady low", 32'(ReqReady), 32'h0);
    @(negedge clk);
    chk("midrst RespValid", 32'(RespValid), 32'h0);
    chk("midrst ReqReady held low", 32'(ReqReady), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst ReqReady after release", 32'(ReqReady), 32'h1);
    chk("midrst no RespValid after release", 32'(RespValid), 32'h0);

    // Normal operation after the abort
    push_beat(32'h104, 4'b0011, 32'h0, 1'b0);
    do_req("ld_h_104_post", 1'b0, 2'b01, 1'b0, 32'h104, 32'h0, 32'h00006655, 1'b0, 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
